// File: rtl/unified_mem_arbiter.sv
// Arbiter giving one single-ported memory to fetch and data requests, with data taking priority.
// Optional build macro ARB_PERF_EN adds saturating conflict and access counters.
module unified_mem_arbiter #(
  parameter int MEM_LAT = 1,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  input  logic          if_flush_i,
  output logic [31:0]   if_rdata_o,
  output logic          if_ready_o,
  input  logic          d_req_i,
  input  logic          d_we_i,
  input  logic [3:0]    d_be_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [31:0]   d_wdata_i,
  output logic [31:0]   d_rdata_o,
  output logic          d_ready_o,
  output logic          stall_if_o,
  output logic          stall_mem_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [3:0]    mem_be_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [31:0]   mem_wdata_o,
`ifdef ARB_PERF_EN
  output logic [31:0]   perf_conflict_o,
  output logic [31:0]   perf_access_o,
`endif
  input  logic [31:0]   mem_rdata_i
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

  state_t        state_q;
  logic          owner_d_q;
  logic          store_q;
  logic          kill_q;
  logic [3:0]    cnt_q;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [3:0]    mem_be_q;
  logic [AW-1:0] mem_addr_q;
  logic [31:0]   mem_wdata_q;
  logic [31:0]   if_rdata_q;
  logic [31:0]   d_rdata_q;
  logic          if_ready_q;
  logic          d_ready_q;
  logic          flush_hit_s;

  // A flush that lands in the capture cycle itself must also suppress the fetch result.
  assign flush_hit_s = if_flush_i & ~owner_d_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_d_q   <= 1'b0;
      store_q     <= 1'b0;
      kill_q      <= 1'b0;
      cnt_q       <= 4'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= 4'd0;
      mem_addr_q  <= {AW{1'b0}};
      mem_wdata_q <= 32'd0;
      if_rdata_q  <= 32'd0;
      d_rdata_q   <= 32'd0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
    end else begin
      if_ready_q <= 1'b0;
      d_ready_q  <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          kill_q <= 1'b0;
          if (d_req_i) begin
            owner_d_q   <= 1'b1;
            store_q     <= d_we_i;
            mem_en_q    <= 1'b1;
            mem_we_q    <= d_we_i;
            mem_be_q    <= d_be_i;
            mem_addr_q  <= d_addr_i;
            mem_wdata_q <= d_wdata_i;
            state_q     <= ISSUE;
          end else if (if_req_i && !if_flush_i) begin
            owner_d_q  <= 1'b0;
            store_q    <= 1'b0;
            mem_en_q   <= 1'b1;
            mem_be_q   <= 4'hF;
            mem_addr_q <= if_addr_i;
            state_q    <= ISSUE;
          end else begin
            state_q <= IDLE;
          end
        end
        ISSUE: begin
          cnt_q <= CNT_INIT;
          if (flush_hit_s) kill_q <= 1'b1;
          state_q <= WAIT;
        end
        WAIT: begin
          if (flush_hit_s) kill_q <= 1'b1;
          if (cnt_q == 4'd0) begin
            state_q <= DONE;
            if (owner_d_q) begin
              if (!store_q) d_rdata_q <= mem_rdata_i;
              d_ready_q <= 1'b1;
            end else if (!(kill_q || flush_hit_s)) begin
              if_rdata_q <= mem_rdata_i;
              if_ready_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_EN
  logic [31:0] perf_conflict_q;
  logic [31:0] perf_access_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_q <= 32'd0;
      perf_access_q   <= 32'd0;
    end else begin
      if (state_q == IDLE && d_req_i && if_req_i && perf_conflict_q != 32'hFFFF_FFFF)
        perf_conflict_q <= perf_conflict_q + 32'd1;
      if (state_q == ISSUE && perf_access_q != 32'hFFFF_FFFF)
        perf_access_q <= perf_access_q + 32'd1;
    end
  end

  assign perf_conflict_o = perf_conflict_q;
  assign perf_access_o   = perf_access_q;
`endif

  assign if_rdata_o  = if_rdata_q;
  assign if_ready_o  = if_ready_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_ready_o   = d_ready_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_be_o    = mem_be_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign stall_if_o  = if_req_i & ~if_ready_q;
  assign stall_mem_o = d_req_i & ~d_ready_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed, table-driven bench for unified_mem_arbiter (MEM_LAT=1 instance plus a MEM_LAT=3 instance).
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, if_req, if_flush, d_req, d_we;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;

  logic [31:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1;
  logic        if_ready1, d_ready1, stall_if1, stall_mem1, mem_en1, mem_we1;
  logic [3:0]  mem_be1;
  logic [31:0] if_rdata3, d_rdata3, mem_addr3, mem_wdata3;
  logic        if_ready3, d_ready3, stall_if3, stall_mem3, mem_en3, mem_we3;
  logic [3:0]  mem_be3;
`ifdef ARB_PERF_EN
  logic [31:0] pc1, pa1, pc3, pa3;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.MEM_LAT(1), .AW(32)) u1 (
    .clk(clk), .rst(rst), .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_rdata_o(if_rdata1), .if_ready_o(if_ready1), .d_req_i(d_req), .d_we_i(d_we),
    .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_rdata_o(d_rdata1),
    .d_ready_o(d_ready1), .stall_if_o(stall_if1), .stall_mem_o(stall_mem1),
    .mem_en_o(mem_en1), .mem_we_o(mem_we1), .mem_be_o(mem_be1), .mem_addr_o(mem_addr1),
    .mem_wdata_o(mem_wdata1),
`ifdef ARB_PERF_EN
    .perf_conflict_o(pc1), .perf_access_o(pa1),
`endif
    .mem_rdata_i(mem_rdata));

  unified_mem_arbiter #(.MEM_LAT(3), .AW(32)) u3 (
    .clk(clk), .rst(rst), .if_req_i(if_req), .if_addr_i(if_addr), .if_flush_i(if_flush),
    .if_rdata_o(if_rdata3), .if_ready_o(if_ready3), .d_req_i(d_req), .d_we_i(d_we),
    .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata), .d_rdata_o(d_rdata3),
    .d_ready_o(d_ready3), .stall_if_o(stall_if3), .stall_mem_o(stall_mem3),
    .mem_en_o(mem_en3), .mem_we_o(mem_we3), .mem_be_o(mem_be3), .mem_addr_o(mem_addr3),
    .mem_wdata_o(mem_wdata3),
`ifdef ARB_PERF_EN
    .perf_conflict_o(pc3), .perf_access_o(pa3),
`endif
    .mem_rdata_i(mem_rdata));

  // ins = {rst, d_req, d_we, if_req, if_flush}; ex = {mem_en, mem_we, if_ready, d_ready, stall_if, stall_mem}
  typedef struct {
    logic [4:0]  ins;
    logic [31:0] da, ia, mrd;
    logic [5:0]  ex;
    logic [31:0] maddr, ifd, dd;
  } vec_t;

  localparam int NV = 37;
  vec_t tv[NV];

  function automatic vec_t mk(input logic [4:0] ins, input logic [31:0] da, ia, mrd,
                              input logic [5:0] ex, input logic [31:0] maddr, ifd, dd);
    vec_t v;
    v.ins = ins; v.da = da; v.ia = ia; v.mrd = mrd;
    v.ex = ex; v.maddr = maddr; v.ifd = ifd; v.dd = dd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_flush = 1'b0; d_req = 1'b0; d_we = 1'b0;
    if_addr = 32'd0; d_addr = 32'd0; mem_rdata = 32'd0;
  endtask

  task automatic do_reset();
    nxt(); rst = 1'b1; clear_inputs();
    nxt(); nxt(); rst = 1'b0;
  endtask

  localparam logic [31:0] A = 32'h0050_0093, B = 32'h1111_1111, G = 32'h2222_2222;
  localparam logic [31:0] C = 32'h3333_3333, D = 32'h6666_6666, E = 32'h4444_4444;

  int ready_at;

  initial begin
    rst = 1'b1; d_be = 4'hF; d_wdata = 32'hDEAD_BEEF; clear_inputs();
    tv[0]  = mk(5'b00000, 32'h00, 32'h00, 32'd0, 6'b000000, 32'h00, 32'd0, 32'd0);
    tv[1]  = mk(5'b00010, 32'h00, 32'h10, A,     6'b000010, 32'h00, 32'd0, 32'd0);
    tv[2]  = mk(5'b00010, 32'h00, 32'h10, A,     6'b100010, 32'h10, 32'd0, 32'd0);
    tv[3]  = mk(5'b00010, 32'h00, 32'h10, A,     6'b000010, 32'h00, 32'd0, 32'd0);
    tv[4]  = mk(5'b00010, 32'h00, 32'h10, A,     6'b001000, 32'h00, A,     32'd0);
    tv[5]  = mk(5'b00000, 32'h00, 32'h00, A,     6'b000000, 32'h00, A,     32'd0);
    tv[6]  = mk(5'b01110, 32'h40, 32'h20, B,     6'b000011, 32'h00, A,     32'd0);
    tv[7]  = mk(5'b01110, 32'h40, 32'h20, B,     6'b110011, 32'h40, A,     32'd0);
    tv[8]  = mk(5'b01110, 32'h40, 32'h20, B,     6'b000011, 32'h00, A,     32'd0);
    tv[9]  = mk(5'b01110, 32'h40, 32'h20, B,     6'b000110, 32'h00, A,     32'd0);
    tv[10] = mk(5'b00010, 32'h00, 32'h20, B,     6'b000010, 32'h00, A,     32'd0);
    tv[11] = mk(5'b00010, 32'h00, 32'h20, B,     6'b100010, 32'h20, A,     32'd0);
    tv[12] = mk(5'b00010, 32'h00, 32'h20, B,     6'b000010, 32'h00, A,     32'd0);
    tv[13] = mk(5'b00010, 32'h00, 32'h20, B,     6'b001000, 32'h00, B,     32'd0);
    tv[14] = mk(5'b00000, 32'h00, 32'h00, B,     6'b000000, 32'h00, B,     32'd0);
    tv[15] = mk(5'b00010, 32'h00, 32'h30, G,     6'b000010, 32'h00, B,     32'd0);
    tv[16] = mk(5'b00010, 32'h00, 32'h30, G,     6'b100010, 32'h30, B,     32'd0);
    tv[17] = mk(5'b00001, 32'h00, 32'h30, G,     6'b000000, 32'h00, B,     32'd0);
    tv[18] = mk(5'b00000, 32'h00, 32'h00, G,     6'b000000, 32'h00, B,     32'd0);
    tv[19] = mk(5'b00010, 32'h00, 32'h34, C,     6'b000010, 32'h00, B,     32'd0);
    tv[20] = mk(5'b00010, 32'h00, 32'h34, C,     6'b100010, 32'h34, B,     32'd0);
    tv[21] = mk(5'b00010, 32'h00, 32'h34, C,     6'b000010, 32'h00, B,     32'd0);
    tv[22] = mk(5'b00010, 32'h00, 32'h34, C,     6'b001000, 32'h00, C,     32'd0);
    tv[23] = mk(5'b00011, 32'h00, 32'h38, D,     6'b000010, 32'h00, C,     32'd0);
    tv[24] = mk(5'b00010, 32'h00, 32'h38, D,     6'b000010, 32'h00, C,     32'd0);
    tv[25] = mk(5'b00010, 32'h00, 32'h38, D,     6'b100010, 32'h38, C,     32'd0);
    tv[26] = mk(5'b00010, 32'h00, 32'h38, D,     6'b000010, 32'h00, C,     32'd0);
    tv[27] = mk(5'b00010, 32'h00, 32'h38, D,     6'b001000, 32'h00, D,     32'd0);
    tv[28] = mk(5'b00000, 32'h00, 32'h00, D,     6'b000000, 32'h00, D,     32'd0);
    tv[29] = mk(5'b01000, 32'h44, 32'h00, E,     6'b000001, 32'h00, D,     32'd0);
    tv[30] = mk(5'b01000, 32'h44, 32'h00, E,     6'b100001, 32'h44, D,     32'd0);
    tv[31] = mk(5'b11000, 32'h44, 32'h00, E,     6'b000001, 32'h00, D,     32'd0);
    tv[32] = mk(5'b01000, 32'h44, 32'h00, E,     6'b000001, 32'h00, 32'd0, 32'd0);
    tv[33] = mk(5'b01000, 32'h44, 32'h00, E,     6'b100001, 32'h44, 32'd0, 32'd0);
    tv[34] = mk(5'b01000, 32'h44, 32'h00, E,     6'b000001, 32'h00, 32'd0, 32'd0);
    tv[35] = mk(5'b01000, 32'h44, 32'h00, E,     6'b000100, 32'h00, 32'd0, E);
    tv[36] = mk(5'b00000, 32'h00, 32'h00, E,     6'b000000, 32'h00, 32'd0, E);

    do_reset();
    for (int i = 0; i < NV; i++) begin
      nxt();
      {rst, d_req, d_we, if_req, if_flush} = tv[i].ins;
      d_addr = tv[i].da; if_addr = tv[i].ia; mem_rdata = tv[i].mrd;
      @(negedge clk);
      chk($sformatf("r%0d mem_en", i),    {31'd0, mem_en1},    {31'd0, tv[i].ex[5]});
      chk($sformatf("r%0d mem_we", i),    {31'd0, mem_we1},    {31'd0, tv[i].ex[4]});
      chk($sformatf("r%0d if_ready", i),  {31'd0, if_ready1},  {31'd0, tv[i].ex[3]});
      chk($sformatf("r%0d d_ready", i),   {31'd0, d_ready1},   {31'd0, tv[i].ex[2]});
      chk($sformatf("r%0d stall_if", i),  {31'd0, stall_if1},  {31'd0, tv[i].ex[1]});
      chk($sformatf("r%0d stall_mem", i), {31'd0, stall_mem1}, {31'd0, tv[i].ex[0]});
      chk($sformatf("r%0d if_rdata", i),  if_rdata1, tv[i].ifd);
      chk($sformatf("r%0d d_rdata", i),   d_rdata1,  tv[i].dd);
      if (tv[i].ex[5]) chk($sformatf("r%0d mem_addr", i), mem_addr1, tv[i].maddr);
      if (tv[i].ex[5] && tv[i].ex[4]) begin
        chk($sformatf("r%0d mem_wdata", i), mem_wdata1, 32'hDEAD_BEEF);
        chk($sformatf("r%0d mem_be", i), {28'd0, mem_be1}, 32'h0000_000F);
      end
    end

    // MEM_LAT=3 load: data must be sampled exactly in C+4, ready pulse in C+5
    do_reset();
    ready_at = -1;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) nxt();
      d_req = (ready_at < 0); d_we = 1'b0; d_addr = 32'h80;
      mem_rdata = (k == 4) ? 32'h5555_5555 : 32'hBAD0_BAD0;
      @(negedge clk);
      if (k <= 6) chk($sformatf("lat3 c%0d mem_en", k), {31'd0, mem_en3}, {31'd0, (k == 1)});
      if (k == 1) chk("lat3 mem_addr", mem_addr3, 32'h80);
      if (d_ready3 && ready_at < 0) begin
        ready_at = k;
        chk("lat3 d_rdata", d_rdata3, 32'h5555_5555);
      end
    end
    chk("lat3 ready cycle", ready_at, 32'd5);

`ifdef ARB_PERF_EN
    do_reset();
    for (int n = 0; n < 5; n++) begin
      nxt(); d_req = 1'b1; if_req = 1'b1; if_addr = 32'h100; d_addr = 32'h200;
      for (int w = 0; w < 10; w++) begin
        @(negedge clk);
        if (d_ready1) break;
        nxt();
      end
      nxt(); d_req = 1'b0;
      for (int w = 0; w < 10; w++) begin
        @(negedge clk);
        if (if_ready1) break;
        nxt();
      end
      nxt(); if_req = 1'b0;
    end
    @(negedge clk);
    chk("perf_conflict", pc1, 32'd5);
    chk("perf_access", pa1, 32'd10);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
